// File: rtl/streebog_pkg.sv
// -----------------------------------------------------------------------------
// streebog_pkg
// Shared constants, the message-padder state type and the final-word padding
// helper for the Streebog message path.
//   BLOCK_BITS : message block width (512)
//   WORD_BITS  : host word width (64); BPW bytes per word, WORDS words per block
//   pad_word() : keeps bytes below nbytes, writes 0x01 at byte nbytes (if it
//                falls inside the word), zeroes everything above
// -----------------------------------------------------------------------------
package streebog_pkg;

  localparam int BLOCK_BITS = 512;
  localparam int WORD_BITS  = 64;
  localparam int BPW        = WORD_BITS / 8;
  localparam int WORDS      = BLOCK_BITS / WORD_BITS;
  localparam int NB_W       = $clog2(BPW + 1);
  localparam int LEN_W      = $clog2(BLOCK_BITS + 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    EMIT     = 2'd1,
    EMIT_PAD = 2'd2
  } msgpad_state_t;

  // nbytes==BPW leaves the word untouched: the 0x01 marker then belongs to the
  // next word (or to a separate padding block when the block is full).
  function automatic logic [WORD_BITS-1:0] pad_word(input logic [WORD_BITS-1:0] word,
                                                    input logic [NB_W-1:0]      nbytes);
    logic [WORD_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < BPW; k++) begin
      if (k < int'(nbytes)) begin
        r[8*k +: 8] = word[8*k +: 8];
      end else if (k == int'(nbytes)) begin
        r[8*k +: 8] = 8'h01;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/streebog_msg_pad.sv
// -----------------------------------------------------------------------------
// streebog_msg_pad
// Packs a byte-counted word stream into 512-bit Streebog message blocks and
// applies the final-block padding 0..0 || 0x01 || M. Each block leaves with the
// number of message bits it carries.
//
// Ports
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   clear_i               synchronous abort, wins over any handshake that cycle
//   s_valid_i/s_ready_o   word handshake; s_data_i, s_last_i, s_nbytes_i payload
//   m_valid_o/m_ready_i   block handshake; m_data_o, m_len_o, m_last_o payload
//
// Handshakes: a transfer happens on the rising edge where valid and ready are
// both high; a valid producer holds its payload stable until that edge.
//
// Configuration macro STREEBOG_MSGPAD_BSWAP_EN: byte-reverse each input word
// before storage (big-endian host; valid bytes of a last word are then the
// most significant ones). Undefined: words are stored as received.
//
// Geometry follows streebog_pkg; DATA_WIDTH/WORD_WIDTH must match
// BLOCK_BITS/WORD_BITS because pad_word() is sized by the package.
// -----------------------------------------------------------------------------
module streebog_msg_pad
  import streebog_pkg::*;
#(
  parameter int DATA_WIDTH = BLOCK_BITS,
  parameter int WORD_WIDTH = WORD_BITS
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              clear_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [WORD_WIDTH-1:0]             s_data_i,
  input  logic                              s_last_i,
  input  logic [$clog2(WORD_WIDTH/8+1)-1:0] s_nbytes_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [DATA_WIDTH-1:0]             m_data_o,
  output logic [$clog2(DATA_WIDTH+1)-1:0]   m_len_o,
  output logic                              m_last_o
);

  localparam int NWORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int NBPW   = WORD_WIDTH / 8;
  localparam int CNT_W  = $clog2(NWORDS);
  localparam int LENW   = $clog2(DATA_WIDTH + 1);

  msgpad_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [LENW-1:0]       len_q, len_d;
  logic                  last_q, last_d;
  logic                  pad_pend_q, pad_pend_d;

  logic [WORD_WIDTH-1:0] word_in;
  logic [LENW-1:0]       pad_byte;

`ifdef STREEBOG_MSGPAD_BSWAP_EN
  for (genvar k = 0; k < NBPW; k++) begin : g_bswap
    assign word_in[8*k +: 8] = s_data_i[8*(NBPW-1-k) +: 8];
  end
`else
  assign word_in = s_data_i;
`endif

  // Byte position of the 0x01 marker within the block.
  assign pad_byte = LENW'(cnt_q) * LENW'(NBPW) + LENW'(s_nbytes_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      buf_q      <= '0;
      len_q      <= '0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    len_d      = len_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;

    unique case (state_q)
      FILL: begin
        if (s_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!s_last_i) begin
            buf_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = word_in;
            if (cnt_q == CNT_W'(NWORDS-1)) begin
              state_d = EMIT;
              len_d   = LENW'(DATA_WIDTH);
              last_d  = 1'b0;
            end
          end else begin
            buf_d[cnt_q*WORD_WIDTH +: WORD_WIDTH] = pad_word(word_in, s_nbytes_i);
            state_d = EMIT;
            if (int'(s_nbytes_i) == NBPW && cnt_q == CNT_W'(NWORDS-1)) begin
              // Message fills the block exactly: padding goes in its own block.
              len_d      = LENW'(DATA_WIDTH);
              last_d     = 1'b0;
              pad_pend_d = 1'b1;
            end else begin
              if (int'(s_nbytes_i) == NBPW) begin
                // Full last word: marker lands at byte 0 of the next slot.
                buf_d[(int'(cnt_q)+1)*WORD_WIDTH +: WORD_WIDTH] = WORD_WIDTH'(1);
              end
              len_d  = {pad_byte[LENW-4:0], 3'b000};
              last_d = 1'b1;
            end
          end
        end
      end
      EMIT: begin
        if (m_ready_i) begin
          buf_d = '0;
          cnt_d = '0;
          if (pad_pend_q) begin
            state_d = EMIT_PAD;
            buf_d   = DATA_WIDTH'(1);
            len_d   = '0;
            last_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      EMIT_PAD: begin
        if (m_ready_i) begin
          state_d    = FILL;
          buf_d      = '0;
          cnt_d      = '0;
          pad_pend_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase

    if (clear_i) begin
      state_d    = FILL;
      cnt_d      = '0;
      buf_d      = '0;
      len_d      = '0;
      last_d     = 1'b0;
      pad_pend_d = 1'b0;
    end
  end

  assign s_ready_o = (state_q == FILL);
  assign m_valid_o = (state_q != FILL);
  assign m_data_o  = buf_q;
  assign m_len_o   = len_q;
  assign m_last_o  = last_q;

endmodule

// File: tb/tb_streebog_msg_pad.sv
// -----------------------------------------------------------------------------
// tb_streebog_msg_pad
// Bench for streebog_msg_pad. A byte-level model cuts each message into
// 64-byte blocks and appends the 0x01 marker after the last message byte,
// producing {last, len, data} entries in an expected queue that a monitor
// compares against every block handshake.
// -----------------------------------------------------------------------------
module tb_streebog_msg_pad;

  localparam int DW = 512;
  localparam int WW = 64;
  localparam int EW = 1 + 10 + DW;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          clear_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [WW-1:0] s_data_i;
  logic          s_last_i;
  logic [3:0]    s_nbytes_i;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic [9:0]    m_len_o;
  logic          m_last_o;

  streebog_msg_pad dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clear_i    (clear_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .s_last_i   (s_last_i),
    .s_nbytes_i (s_nbytes_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_data_o   (m_data_o),
    .m_len_o    (m_len_o),
    .m_last_o   (m_last_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    msg_q[$];

  task automatic check_eq(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: full 64-byte chunks go out unpadded; the tail (0..63 bytes)
  // gets 0x01 right after it and carries 8*tail bits.
  task automatic model_msg();
    int L;
    int full;
    int rem;
    logic [DW-1:0] blk;
    L    = msg_q.size();
    full = L / 64;
    for (int b = 0; b < full; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[8*i +: 8] = msg_q[64*b + i];
      exp_q.push_back({1'b0, 10'd512, blk});
    end
    rem = L - 64*full;
    blk = '0;
    for (int i = 0; i < rem; i++) blk[8*i +: 8] = msg_q[64*full + i];
    blk[8*rem +: 8] = 8'h01;
    exp_q.push_back({1'b1, 10'(8*rem), blk});
  endtask

  // ---------------- monitor ----------------
  logic          hold_q = 1'b0;
  logic [EW-1:0] hold_v;
  logic [EW-1:0] cur;
  logic [EW-1:0] e;

  always @(negedge clk_i) begin
    cur = {m_last_o, m_len_o, m_data_o};
    if (!rstn_i || clear_i) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check_eq("hold_valid", EW'(m_valid_o), EW'(1));
        check_eq("hold_stable", cur, hold_v);
      end
      if (m_valid_o) check_eq("s_ready_blk", EW'(s_ready_o), EW'(0));
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check_eq("unexp_blk", EW'(m_valid_o), EW'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("block", cur, e);
        end
      end
      hold_q = m_valid_o && !m_ready_i;
      hold_v = cur;
    end
  end

  // Illegal word framing never produced by this bench.
  always @(negedge clk_i) begin
    if (rstn_i && s_valid_i && s_ready_o) begin
      assert (s_nbytes_i <= 4'd8 && (s_last_i || s_nbytes_i == 4'd8))
        else $error("illegal word framing nbytes=%0d last=%0b", s_nbytes_i, s_last_i);
    end
  end

  // ---------------- sink ready driver ----------------
  int bp_left = 0;
  always @(posedge clk_i) begin
    #1;
    if (bp_left > 0 && m_valid_o) begin
      m_ready_i = 1'b0;
      bp_left--;
    end else begin
      m_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic drive_words(input int max_w);
    int L;
    int nw;
    int idx;
    int t;
    logic acc;
    logic [7:0] bt;
    L  = msg_q.size();
    nw = (L == 0) ? 1 : (L + 7) / 8;
    if (max_w < nw) nw = max_w;
    for (int w = 0; w < nw; w++) begin
      s_data_i = '0;
      for (int k = 0; k < 8; k++) begin
        idx = 8*w + k;
        bt  = (idx < L) ? msg_q[idx] : 8'($urandom);
`ifdef STREEBOG_MSGPAD_BSWAP_EN
        s_data_i[8*(7-k) +: 8] = bt;
`else
        s_data_i[8*k +: 8] = bt;
`endif
      end
      s_last_i   = (8*w + 8 >= L);
      s_nbytes_i = s_last_i ? 4'(L - 8*w) : 4'd8;
      s_valid_i  = 1'b1;
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge clk_i);
        acc = s_ready_o;
        @(posedge clk_i);
        #1;
        t++;
      end
      check_eq("accept_to", EW'(acc), EW'(1));
      s_valid_i = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic send_msg(input int len_b, input int mode);
    msg_q.delete();
    for (int i = 0; i < len_b; i++) begin
      case (mode)
        0:       msg_q.push_back(8'($urandom));
        1:       msg_q.push_back(8'hAA);
        default: msg_q.push_back(8'(3*i + 1));
      endcase
    end
    model_msg();
    drive_words(1000);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    check_eq("drain", EW'(exp_q.size()), EW'(0));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_s_ready"}, EW'(s_ready_o), EW'(1));
    check_eq({tag, "_m_valid"}, EW'(m_valid_o), EW'(0));
    check_eq({tag, "_m_data"},  EW'(m_data_o),  EW'(0));
    check_eq({tag, "_m_len"},   EW'(m_len_o),   EW'(0));
    check_eq({tag, "_m_last"},  EW'(m_last_o),  EW'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn_i     = 1'b0;
    clear_i    = 1'b0;
    s_valid_i  = 1'b0;
    s_data_i   = '0;
    s_last_i   = 1'b0;
    s_nbytes_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_idle_outputs("reset");
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    // Empty message, exact 63-byte and 64-byte boundaries.
    send_msg(0, 0);
    send_msg(63, 1);
    send_msg(64, 1);
    drain();

    // Backpressure on the first block of a two-block message.
    bp_left = 5;
    send_msg(100, 2);
    drain();

    // Randomised message lengths, including word and block boundaries.
    for (int n = 0; n < 24; n++) begin
      send_msg($urandom_range(0, 200), 0);
    end
    send_msg(72, 0);
    send_msg(128, 0);
    send_msg(8, 0);
    drain();

    // Abort after 3 words, with a word offered in the clear cycle.
    msg_q.delete();
    for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom));
    drive_words(3);
    s_data_i   = 64'($urandom);
    s_last_i   = 1'b1;
    s_nbytes_i = 4'd8;
    s_valid_i  = 1'b1;
    clear_i    = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i   = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("clr_s_ready", EW'(s_ready_o), EW'(1));
    check_eq("clr_m_valid", EW'(m_valid_o), EW'(0));
    check_eq("clr_m_data",  EW'(m_data_o),  EW'(0));
    @(posedge clk_i);
    #1;
    msg_q.delete();
    msg_q.push_back(8'h02);
    msg_q.push_back(8'h01);
    model_msg();
    drive_words(1000);
    drain();

    // Reset with 3 words of a message already accepted.
    msg_q.delete();
    for (int i = 0; i < 40; i++) msg_q.push_back(8'($urandom));
    drive_words(3);
    rstn_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("midrst");
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    send_msg(70, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
